mem_responder: RTL and testbench

- Word-addressed data-memory responder serving the CPU's load/store initiator over a req/ack handshake.
- Fixed, parameterised wait-state latency models a slow memory.
- Captures address, write-enable and write data on request; performs the access after LATENCY cycles; returns a one-cycle ack with read data or an error flag.
- Sits between the datapath's memory stage and the data storage array.

---
 rtl/mem_if.sv | 13 +
 rtl/mem_responder.sv | 62 ++++++
 tb/tb_mem_responder.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_if.sv
// mem_if: req/ack load/store bus between the CPU memory stage and the data memory responder
interface mem_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        err;
  logic        busy;
  modport master (output req, we, addr, wdata, input rdata, ack, err, busy);
  modport slave  (input req, we, addr, wdata, output rdata, ack, err, busy);
endinterface

// File: rtl/mem_responder.sv
// mem_responder: word-addressed data memory answering one request at a time after a fixed wait-state latency
module mem_responder #(
  parameter int          DEPTH   = 64,
  parameter int          LATENCY = 2,
  parameter logic [31:0] BASE    = 32'h0000_0000
) (
  input logic   clk,
  input logic   reset,
  mem_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t          state_q, state_d;
  logic [3:0]      count_q, count_d;
  logic            we_q;
  logic [31:0]     addr_q, wdata_q, rdata_q;
  logic [31:0]     mem [DEPTH];
  logic [32:0]     a33, lo, hi, off;
  logic [AW-1:0]   idx;
  logic            valid, cap, fire;
  // 33-bit range check so BASE+4*DEPTH cannot wrap at the top of the address space
  assign a33   = {1'b0, addr_q};
  assign lo    = {1'b0, BASE};
  assign hi    = lo + 33'(4 * DEPTH - 4);
  assign off   = a33 - lo;
  assign idx   = AW'(off >> 2);
  assign valid = addr_q[1:0] == 2'b00 && a33 >= lo && a33 <= hi;
  assign cap   = state_q == IDLE && bus.req;
  assign fire  = state_q == WAIT && count_q == 4'd0;
  always_comb begin
    state_d = state_q;
    count_d = state_q == IDLE ? 4'(LATENCY - 1) : count_q - 4'd1;
    unique case (state_q)
      IDLE:    state_d = bus.req ? WAIT : IDLE;
      WAIT:    state_d = count_q == 4'd0 ? RESP : WAIT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (cap) {we_q, addr_q, wdata_q} <= {bus.we, bus.addr, bus.wdata};
      if (fire && valid && !we_q) rdata_q <= mem[idx];
    end
  end
  // storage is deliberately not reset; its state only advances through committed stores
  always_ff @(posedge clk) begin
    if (fire && valid && we_q) mem[idx] <= wdata_q;
  end
  assign bus.ack   = state_q == RESP;
  assign bus.err   = state_q == RESP && !valid;
  assign bus.busy  = state_q != IDLE;
  assign bus.rdata = rdata_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized and directed checks of mem_responder against a word-array reference model
module tb_mem_responder;
  logic        clk = 1'b0, reset = 1'b1, req = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  sel = '0;
  int          checks = 0, fails = 0;
  int          lat [4] = '{2, 1, 15, 2};
  logic [31:0] base [4] = '{32'h0, 32'h0, 32'h0, 32'h2000};
  bit   [31:0] mm [4][64];
  bit          wr [4][64];
  logic [31:0] exp_rd [4];
  bit          known [4];

  mem_if b0(), b1(), b2(), b3();
  assign {b0.req, b0.we, b0.addr, b0.wdata} = {req & sel[0], we, addr, wdata};
  assign {b1.req, b1.we, b1.addr, b1.wdata} = {req & sel[1], we, addr, wdata};
  assign {b2.req, b2.we, b2.addr, b2.wdata} = {req & sel[2], we, addr, wdata};
  assign {b3.req, b3.we, b3.addr, b3.wdata} = {req & sel[3], we, addr, wdata};

  mem_responder #(.LATENCY(2))             u0 (.clk(clk), .reset(reset), .bus(b0));
  mem_responder #(.LATENCY(1))             u1 (.clk(clk), .reset(reset), .bus(b1));
  mem_responder #(.LATENCY(15))            u2 (.clk(clk), .reset(reset), .bus(b2));
  mem_responder #(.BASE(32'h0000_2000))    u3 (.clk(clk), .reset(reset), .bus(b3));

  always #5 clk = ~clk;

  function automatic logic [34:0] outs(input int k);
    case (k)
      0:       return {b0.ack, b0.err, b0.busy, b0.rdata};
      1:       return {b1.ack, b1.err, b1.busy, b1.rdata};
      2:       return {b2.ack, b2.err, b2.busy, b2.rdata};
      default: return {b3.ack, b3.err, b3.busy, b3.rdata};
    endcase
  endfunction

  function automatic bit ok(input int k, input logic [31:0] a);
    longint unsigned ua = a, ub = base[k];
    return a[1:0] == 2'b00 && ua >= ub && ua < ub + 256;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 4; k++) begin
      exp_rd[k] = '0;
      known[k]  = 1'b1;
    end
  endfunction

  task automatic txn(input int k, input bit w, input logic [31:0] a, input logic [31:0] d);
    int L, idx;
    bit v;
    logic [34:0] o;
    L = lat[k];
    v = ok(k, a);
    idx = int'((a - base[k]) >> 2) & 63;
    @(negedge clk);
    sel = 4'(1 << k); req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk);
    for (int n = 0; n <= L + 1; n++) begin
      @(negedge clk);
      if (n == 0) req = 1'b0;
      o = outs(k);
      checks++;
      if (o[34] !== (n == L)) begin fails++; $display("FAIL ack k=%0d addr=%h n=%0d: got %b expected %b", k, a, n, o[34], n == L); end
      checks++;
      if (o[32] !== (n <= L)) begin fails++; $display("FAIL busy k=%0d addr=%h n=%0d: got %b expected %b", k, a, n, o[32], n <= L); end
      if (n == L) begin
        if (v && w) begin mm[k][idx] = d; wr[k][idx] = 1'b1; end
        if (v && !w) begin exp_rd[k] = mm[k][idx]; known[k] = wr[k][idx]; end
        checks++;
        if (o[33] !== !v) begin fails++; $display("FAIL err k=%0d addr=%h: got %b expected %b", k, a, o[33], !v); end
        if (known[k]) begin
          checks++;
          if (o[31:0] !== exp_rd[k]) begin fails++; $display("FAIL rdata k=%0d addr=%h: got %h expected %h", k, a, o[31:0], exp_rd[k]); end
        end
      end else begin
        checks++;
        if (o[33] !== 1'b0) begin fails++; $display("FAIL err_no_ack k=%0d n=%0d: got %b expected 0", k, n, o[33]); end
      end
    end
  endtask

  task automatic test_reset();
    logic [34:0] o;
    reset = 1'b1;
    model_reset();
    #1;
    for (int k = 0; k < 4; k++) begin
      o = outs(k);
      checks++;
      if (o !== 35'd0) begin fails++; $display("FAIL reset_outs k=%0d: got %h expected 0", k, o); end
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    o = outs(0);
    checks++;
    if (o !== 35'd0) begin fails++; $display("FAIL post_reset_idle: got %h expected 0", o); end
  endtask

  task automatic test_store_load();
    txn(0, 1'b1, 32'h8, 32'hDEADBEEF);
    txn(0, 1'b0, 32'h8, 32'h0);
  endtask

  task automatic test_errors();
    txn(0, 1'b1, 32'h0, 32'h0BAD_F00D);
    txn(0, 1'b0, 32'h6, 32'h0);
    txn(0, 1'b1, 32'h100, 32'h1111_2222);
    txn(0, 1'b0, 32'h0, 32'h0);
    txn(0, 1'b1, 32'hFC, 32'hCAFE_0FFC);
    txn(0, 1'b0, 32'hFC, 32'h0);
  endtask

  task automatic test_held();
    logic [34:0] o;
    int last = -1;
    @(negedge clk);
    sel = 4'b0001; req = 1'b1; we = 1'b0; addr = 32'h0;
    @(posedge clk);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      o = outs(0);
      checks++;
      if (o[34] !== (c % 4 == 2)) begin fails++; $display("FAIL held_ack c=%0d: got %b expected %b", c, o[34], c % 4 == 2); end
      checks++;
      if (o[32] !== (c % 4 != 3)) begin fails++; $display("FAIL held_busy c=%0d: got %b expected %b", c, o[32], c % 4 != 3); end
      if (o[34]) begin
        checks++;
        if (o[31:0] !== mm[0][0]) begin fails++; $display("FAIL held_rdata c=%0d: got %h expected %h", c, o[31:0], mm[0][0]); end
        if (last >= 0) begin
          checks++;
          if (c - last !== 4) begin fails++; $display("FAIL held_spacing: got %0d expected 4", c - last); end
        end
        last = c;
      end
    end
    req = 1'b0;
    o = outs(0);
    for (int i = 0; i < 8 && o[32]; i++) begin
      @(negedge clk);
      o = outs(0);
    end
    checks++;
    if (o[32] !== 1'b0) begin fails++; $display("FAIL held_drain: busy got %b expected 0", o[32]); end
    exp_rd[0] = mm[0][0];
  endtask

  task automatic test_late_change();
    logic [34:0] o;
    txn(0, 1'b1, 32'h14, 32'h0000_0055);
    @(negedge clk);
    sel = 4'b0001; req = 1'b1; we = 1'b1; addr = 32'h10; wdata = 32'h11;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0; addr = 32'h14; wdata = 32'h22;
    o = outs(0);
    for (int i = 0; i < 6 && !o[34]; i++) begin
      @(negedge clk);
      o = outs(0);
    end
    checks++;
    if (o[34] !== 1'b1) begin fails++; $display("FAIL late_ack: got %b expected 1", o[34]); end
    mm[0][4] = 32'h11; wr[0][4] = 1'b1;
    @(negedge clk);
    txn(0, 1'b0, 32'h10, 32'h0);
    txn(0, 1'b0, 32'h14, 32'h0);
  endtask

  task automatic test_reset_mid();
    logic [34:0] o;
    txn(0, 1'b1, 32'h20, 32'h1234);
    @(negedge clk);
    sel = 4'b0001; req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'hAAAA5555;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    #2 reset = 1'b1;
    model_reset();
    #1;
    o = outs(0);
    checks++;
    if (o !== 35'd0) begin fails++; $display("FAIL mid_reset_outs: got %h expected 0", o); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      o = outs(0);
      checks++;
      if (o[34] !== 1'b0) begin fails++; $display("FAIL mid_reset_no_ack i=%0d: got %b expected 0", i, o[34]); end
    end
    txn(0, 1'b0, 32'h20, 32'h0);
  endtask

  task automatic test_params();
    txn(1, 1'b1, 32'h8, 32'hDEADBEEF);
    txn(1, 1'b0, 32'h8, 32'h0);
    txn(2, 1'b1, 32'h8, 32'hDEADBEEF);
    txn(2, 1'b0, 32'h8, 32'h0);
    txn(3, 1'b1, 32'h2000, 32'h5A5A_A5A5);
    txn(3, 1'b0, 32'h2000, 32'h0);
    txn(3, 1'b0, 32'h1FFC, 32'h0);
    txn(3, 1'b0, 32'h2100, 32'h0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 60; t++) begin
      int k = int'($urandom_range(0, 3));
      logic [31:0] a = base[k] + 32'($urandom_range(0, 72)) * 4;
      if ($urandom_range(0, 6) == 0) a = a + 32'($urandom_range(1, 3));
      if (k == 3 && $urandom_range(0, 7) == 0) a = base[k] - 32'($urandom_range(1, 8)) * 4;
      txn(k, 1'($urandom_range(0, 1)), a, $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_errors();
    test_held();
    test_late_change();
    test_reset_mid();
    test_params();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
